// File: rtl/ioctl_song_writer.sv
// On-chip note sequencer: replays 10-byte ROM events as 8 ioctl register writes, then gates the synth.
// Optional build macro SEQ_LOOP_EN: the end marker rewinds to ROM byte 0 instead of entering DONE.
module ioctl_song_writer #(
  parameter logic [7:0]  INDEX     = 8'd2,
  parameter int unsigned ROM_AW    = 10,
  parameter int unsigned TICK_DIV  = 24000,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              start,
  input  logic              stop,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              ioctl_wr,
  output logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_index,
  input  logic              ioctl_wait,
  output logic              trigger_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned EVT_BYTES = 10;
  localparam int unsigned FCNT_W    = 4;
  localparam int unsigned DUR_W     = 16;
  localparam int unsigned DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CHECK, S_WRITE, S_NOTE, S_GAP, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ROM_AW-1:0]   ptr_q, ptr_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [2:0]          k_q, k_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DUR_W-1:0]    tick_q, tick_d;
  logic [7:0]          evt_q [EVT_BYTES];
  logic [7:0]          evt_d [EVT_BYTES];
  logic [2:0]          addr_q, addr_d;
  logic [7:0]          dout_q, dout_d;
  logic                trig_q, trig_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DUR_W-1:0]    dur;
  logic                tick_end;

  assign dur      = {evt_q[8], evt_q[9]};
  assign tick_end = (div_q == DIV_W'(TICK_DIV - 1));

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      rom_addr_q <= '0;
      fcnt_q     <= '0;
      k_q        <= '0;
      div_q      <= '0;
      tick_q     <= '0;
      for (int i = 0; i < int'(EVT_BYTES); i++) evt_q[i] <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      trig_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      fcnt_q     <= fcnt_d;
      k_q        <= k_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      evt_q      <= evt_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    fcnt_d     = fcnt_q;
    k_d        = k_q;
    div_d      = div_q;
    tick_d     = tick_q;
    evt_d      = evt_q;
    addr_d     = addr_q;
    dout_d     = dout_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_FETCH;
          ptr_d      = '0;
          rom_addr_d = '0;
          fcnt_d     = '0;
        end
      end
      S_FETCH: begin
        // ROM data trails the address by one clock, so capture lags issue by one slot
        if (fcnt_q != '0) evt_d[fcnt_q - FCNT_W'(1)] = rom_data;
        if (fcnt_q == FCNT_W'(EVT_BYTES)) begin
          state_d = S_CHECK;
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
          if (fcnt_q < FCNT_W'(EVT_BYTES - 1))
            rom_addr_d = ptr_q + ROM_AW'(fcnt_q + FCNT_W'(1));
        end
      end
      S_CHECK: begin
        if (dur == '0) begin
`ifdef SEQ_LOOP_EN
          state_d = S_GAP;
          ptr_d   = '0;
          div_d   = '0;
          tick_d  = '0;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_WRITE;
          k_d     = '0;
          addr_d  = '0;
          dout_d  = evt_q[0];
        end
      end
      S_WRITE: begin
        if (!ioctl_wait) begin
          if (k_q == 3'd7) begin
            state_d = S_NOTE;
            div_d   = '0;
            tick_d  = '0;
          end else begin
            k_d    = k_q + 3'd1;
            addr_d = k_q + 3'd1;
            dout_d = evt_q[FCNT_W'(k_q) + FCNT_W'(1)];
          end
        end
      end
      S_NOTE: begin
        if (tick_end) begin
          div_d = '0;
          if (tick_q == dur - DUR_W'(1)) begin
            state_d = S_GAP;
            ptr_d   = ptr_q + ROM_AW'(EVT_BYTES);
            tick_d  = '0;
          end else begin
            tick_d = tick_q + DUR_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_GAP: begin
        if (tick_end) begin
          div_d = '0;
          if (tick_q == DUR_W'(GAP_TICKS - 1)) begin
            state_d    = S_FETCH;
            rom_addr_d = ptr_q;
            fcnt_d     = '0;
          end else begin
            tick_d = tick_q + DUR_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stop overrides everything, including a coincident start
    if (stop) begin
      state_d = S_IDLE;
      ptr_d   = '0;
    end

    trig_d = (state_d != S_NOTE);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // Strobe is qualified by the consumer stall in the same cycle
  assign ioctl_wr    = (state_q == S_WRITE) && !ioctl_wait;
  assign ioctl_addr  = {22'd0, addr_q};
  assign ioctl_dout  = dout_q;
  assign ioctl_index = INDEX;
  assign rom_addr    = rom_addr_q;
  assign trigger_out = trig_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ioctl_song_writer.sv
// Directed bench for ioctl_song_writer: sync ROM model, strobe log, gate-low counter.
module tb_ioctl_song_writer;

  localparam int unsigned ROM_AW = 10;
  localparam int unsigned ROM_SZ = 1 << ROM_AW;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              ioctl_wait = 1'b0;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data = 8'd0;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              trigger_out;
  logic              busy;
  logic              done;

  logic [7:0]  mem [ROM_SZ];
  logic [32:0] wlog [$];
  int          checks = 0;
  int          failures = 0;
  int          low_cnt = 0;
  int          wait_viol = 0;
  bit          done_seen = 1'b0;

  typedef struct {
    logic [7:0]  rom_byte;
    logic [24:0] exp_addr;
    logic [7:0]  exp_dout;
  } vec_t;
  vec_t vt [8];

  ioctl_song_writer #(
    .INDEX(8'd2), .ROM_AW(ROM_AW), .TICK_DIV(4), .GAP_TICKS(2)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .stop(stop),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .trigger_out(trigger_out), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) rom_data <= mem[rom_addr];

  always @(negedge CLK) begin
    if (ioctl_wr) wlog.push_back({ioctl_addr, ioctl_dout});
    if (ioctl_wr && ioctl_wait) wait_viol++;
    if (RESET_N && !trigger_out) low_cnt++;
    if (done) done_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < int'(ROM_SZ); a++) mem[a] = 8'd0;
  endtask

  task automatic load_evt1();
    clear_mem();
    for (int k = 0; k < 8; k++) mem[k] = vt[k].rom_byte;
    mem[8] = 8'h00;
    mem[9] = 8'h03;
  endtask

  task automatic check_frame(input string name);
    chk({name, "_count"}, 32'(wlog.size()), 32'd8);
    for (int k = 0; k < 8 && k < wlog.size(); k++) begin
      chk($sformatf("%s_addr%0d", name, k), 32'(wlog[k][32:8]), 32'(vt[k].exp_addr));
      chk($sformatf("%s_data%0d", name, k), 32'(wlog[k][7:0]), 32'(vt[k].exp_dout));
    end
  endtask

  initial begin
    int lat;
    int n;
    int hits;

    vt[0] = '{8'h11, 25'd0, 8'h11};
    vt[1] = '{8'h25, 25'd1, 8'h25};
    vt[2] = '{8'h02, 25'd2, 8'h02};
    vt[3] = '{8'h07, 25'd3, 8'h07};
    vt[4] = '{8'hFF, 25'd4, 8'hFF};
    vt[5] = '{8'h00, 25'd5, 8'h00};
    vt[6] = '{8'h22, 25'd6, 8'h22};
    vt[7] = '{8'h8C, 25'd7, 8'h8C};
    clear_mem();

    // Reset state
    #12;
    chk("rst_trigger", 32'(trigger_out), 32'd1);
    chk("rst_wr", 32'(ioctl_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_index", 32'(ioctl_index), 32'd2);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_ioctl_addr", 32'(ioctl_addr), 32'd0);
    @(posedge CLK); #1 RESET_N = 1'b1;
    repeat (2) @(posedge CLK);

`ifdef SEQ_LOOP_EN
    // Looping build: two events then marker must repeat with done never high
    clear_mem();
    for (int k = 0; k < 20; k++) mem[k] = 8'(k + 1);
    mem[8] = 8'h00; mem[9] = 8'h01; mem[18] = 8'h00; mem[19] = 8'h01;
    wlog.delete();
    done_seen = 1'b0;
    pulse_start();
    repeat (400) @(negedge CLK);
    chk("loop_no_done", 32'(done_seen), 32'd0);
    chk("loop_repeats", 32'(wlog.size() >= 32), 32'd1);
    hits = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i] == {25'd0, 8'h01}) hits++;
    chk("loop_evt0_twice", 32'(hits >= 2), 32'd1);
    @(posedge CLK); #1 stop = 1'b1;
    @(posedge CLK); #1 stop = 1'b0;
    chk("loop_stop_busy", 32'(busy), 32'd0);
`else
    // Basic event with hand-computed gate length 3 ticks x 4 clocks
    load_evt1();
    wlog.delete();
    low_cnt = 0;
    pulse_start();
    lat = 0;
    while (lat < 20) begin
      @(negedge CLK);
      if (ioctl_wr) break;
      lat++;
    end
    chk("t1_latency_lt14", 32'(lat < 14), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done(300, "t1_done");
    check_frame("t1");
    chk("t1_gate_clocks", 32'(low_cnt), 32'd12);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_trigger_after", 32'(trigger_out), 32'd1);

    // Consumer stall during byte 3
    wlog.delete();
    wait_viol = 0;
    pulse_start();
    n = 0;
    while (n < 40) begin
      @(negedge CLK);
      if (ioctl_wr && ioctl_addr == 25'd2) break;
      n++;
    end
    @(posedge CLK); #1 ioctl_wait = 1'b1;
    repeat (5) @(posedge CLK);
    #1 ioctl_wait = 1'b0;
    wait_done(300, "t2_done");
    check_frame("t2");
    chk("t2_wait_violations", 32'(wait_viol), 32'd0);
    hits = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i][32:8] == 25'd3) hits++;
    chk("t2_byte3_once", 32'(hits), 32'd1);

    // Stop during the gate, then restart from byte 0
    pulse_start();
    n = 0;
    while (n < 60) begin
      @(negedge CLK);
      if (!trigger_out) break;
      n++;
    end
    chk("t3_in_note", 32'(trigger_out), 32'd0);
    repeat (3) @(posedge CLK);
    #1 stop = 1'b1;
    @(posedge CLK); #1 stop = 1'b0;
    chk("t3_stop_trigger", 32'(trigger_out), 32'd1);
    chk("t3_stop_busy", 32'(busy), 32'd0);
    chk("t3_stop_wr", 32'(ioctl_wr), 32'd0);
    wlog.delete();
    repeat (30) @(negedge CLK);
    chk("t3_no_strobes", 32'(wlog.size()), 32'd0);
    chk("t3_idle_not_done", 32'(done), 32'd0);
    pulse_start();
    wait_done(300, "t3_restart_done");
    check_frame("t3r");

    // End marker at ROM byte 0
    clear_mem();
    wlog.delete();
    low_cnt = 0;
    pulse_start();
    wait_done(13, "t4_done_within_13");
    chk("t4_no_strobes", 32'(wlog.size()), 32'd0);
    chk("t4_gate_never_low", 32'(low_cnt), 32'd0);

    // Event straddling the top of the ROM, reached after 102 short events
    for (int a = 0; a < int'(ROM_SZ); a++) mem[a] = 8'(a * 7 + 3);
    for (int e = 0; e < 102; e++) begin
      mem[e * 10 + 8] = 8'h00;
      mem[e * 10 + 9] = 8'h01;
    end
    mem[4] = 8'h00; mem[5] = 8'h01;
    mem[14] = 8'h00; mem[15] = 8'h00;
    wlog.delete();
    pulse_start();
    wait_done(6000, "t5_done");
    chk("t5_strobe_count", 32'(wlog.size()), 32'd824);
    for (int k = 0; k < 8 && 816 + k < wlog.size(); k++) begin
      chk($sformatf("t5_addr%0d", k), 32'(wlog[816 + k][32:8]), 32'(k));
      chk($sformatf("t5_data%0d", k), 32'(wlog[816 + k][7:0]),
          32'(mem[(1020 + k) % int'(ROM_SZ)]));
    end
`endif

    // Asynchronous reset in the middle of a register frame
    load_evt1();
    pulse_start();
    n = 0;
    while (n < 40) begin
      @(negedge CLK);
      if (ioctl_wr) break;
      n++;
    end
    #2 RESET_N = 1'b0;
    #1;
    chk("ar_wr", 32'(ioctl_wr), 32'd0);
    chk("ar_trigger", 32'(trigger_out), 32'd1);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_rom_addr", 32'(rom_addr), 32'd0);
    wlog.delete();
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    repeat (20) @(negedge CLK);
    chk("ar_no_strobes", 32'(wlog.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
